mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs iterative shift-add or restoring-divide steps. While busy, it raises a pipeline stall whenever EX tries to issue another MD op or read HI/LO. The hazard/forwarding logic consumes `stall`; the WB mux reads `hi`/`lo` for MFHI/MFLO.

## Interface
Parameters: none (width fixed at 32).
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: EX holds a valid MD instruction this cycle.
- `md_op` in 3: operation code (`MD_*` from `ctrl_encode_def.v`).
- `opa` in 32: rs value (multiplicand / dividend / MTHI-MTLO source).
- `opb` in 32: rt value (multiplier / divisor).
- `rd_req` in 1: EX holds MFHI or MFLO.
- `cancel` in 1: flush of the issuing instruction; aborts the in-flight op.
- `busy` out 1: operation in progress.
- `stall` out 1: freeze IF/ID/EX this cycle.
- `done` out 1: one-cycle pulse, new HI/LO visible.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE + `start` + !`cancel`:
  - MTHI/MTLO: write `hi`/`lo` at this edge; stay in IDLE; no `busy`, no `done`.
  - MULT/MULTU/DIV/DIVU: latch operands (magnitudes + result sign for signed ops), clear counter, go to CALC.
- CALC: one step per cycle; counter 0..31; exit to FIXUP after step 31.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, one quotient bit per step.
- FIXUP: apply sign correction, write `hi`/`lo`, go to IDLE. `done` is registered, so it is high in the cycle after FIXUP.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=`opa`, no sign fixup.
- `stall = busy & (start | rd_req)`. `start` while busy is ignored; the pipeline holds it via `stall`.
- `cancel` in CALC/FIXUP: next state IDLE; `hi`/`lo` unchanged; no `done`. `cancel` together with `start` in IDLE: start ignored.
- `rst` at any time: state IDLE, counter 0, `hi`=`lo`=0, all outputs 0.

## Timing
- Reset values: `busy`=0, `stall`=0, `done`=0, `hi`=0, `lo`=0.
- Iterative op with start at cycle 0:
  - CALC in cycles 1–32, FIXUP in cycle 33.
  - `busy`=1 in cycles 1–33.
  - `done`=1 and new `hi`/`lo` visible in cycle 34; `busy`=0 in cycle 34.
- A new start is accepted in cycle 34, so back-to-back ops have a 34-cycle issue interval.
- MTHI/MTLO: value visible in the cycle after start.
- `stall` is combinational from `start`/`rd_req` and the registered `busy`; it has no path from `opa`/`opb`.

## Configuration
- Macro: `MDU_FAST_MUL_EN`.
- With the macro defined:
  - MULT/MULTU use a native 32x32 multiplier and spend exactly 1 CALC cycle.
  - `busy` covers cycles 1–2; `done` fires in cycle 3.
- Without the macro: 32-step shift-add multiply as above.
- Divide timing is identical in both builds.

## Structure
- Add `MD_MULT`=3'd0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5 to `ctrl_encode_def.v`.
- Add the state encodings `MDS_IDLE`/`MDS_CALC`/`MDS_FIXUP` to the same file.
- One sub-module, `mdu_iter_step`: combinational single shift-add / restoring-subtract step on the {acc, operand} pair, selected by a mul/div flag.
- FSM, counter, sign latch and HI/LO registers stay in `mdu_ctrl`.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` in cycle 34 (cycle 3 with `MDU_FAST_MUL_EN`). MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MULT started, `rd_req`=1 held -> `stall`=1 in cycles 1–33, 0 in cycle 34, with the correct `lo` visible there. A second `start` in cycle 5 is ignored.
- DIV started, `cancel` in cycle 10 -> `busy`=0 from cycle 11, `hi`/`lo` keep their prior values, no `done`. `rst` in cycle 10 of another op -> `hi`=`lo`=0, IDLE.
- MTHI 0x00001234 in IDLE -> `hi`=0x00001234 next cycle, `busy` never asserted. MTLO issued while busy -> stalled until cycle 34, then applied.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - MD opcode and sequencer state encodings shared by the multiply/divide unit
package mdu_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDS_IDLE  = 2'd0,
        MDS_CALC  = 2'd1,
        MDS_FIXUP = 2'd2
    } mds_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one shift-add multiply or restoring-divide step on the {acc, q} pair
module mdu_iter_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] q,
    input  logic [31:0] m,
    output logic [31:0] acc_nxt,
    output logic [31:0] q_nxt
);

    logic [32:0] sum;
    logic [32:0] rem;
    logic [33:0] diff;

    // Multiply shifts {acc, q} right after a conditional add; divide shifts left and trial-subtracts.
    // The subtract is 34 bits wide so a zero divisor (acc may reach 2^32-1) still never borrows.
    always_comb begin
        sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
        rem  = {acc, q[31]};
        diff = {1'b0, rem} - {2'b00, m};
        if (is_div) begin
            if (!diff[33]) begin
                acc_nxt = diff[31:0];
                q_nxt   = {q[30:0], 1'b1};
            end else begin
                acc_nxt = rem[31:0];
                q_nxt   = {q[30:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[32:1];
            q_nxt   = {sum[0], q[31:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/DIV sequencer owning HI/LO; optional MDU_FAST_MUL_EN
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        rd_req,
    input  logic        cancel,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mds_e        state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;
    logic [31:0] m_reg;
    logic [31:0] acc;
    logic [31:0] q;
    logic [31:0] acc_nxt;
    logic [31:0] q_nxt;

    logic        op_div;
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    mdu_iter_step u_step (
        .is_div  (is_div),
        .acc     (acc),
        .q       (q),
        .m       (m_reg),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, m_reg} * {32'd0, q};
`endif

    assign stall = busy & (start | rd_req);

    // Decode the issuing op and take operand magnitudes for signed forms.
    always_comb begin
        op_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
        op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
        a_mag     = op_signed ? abs32(opa) : opa;
        b_mag     = op_signed ? abs32(opb) : opb;
    end

    // Sign correction of the raw magnitude result, applied in FIXUP.
    always_comb begin
        prod_fix = neg_lo ? (64'd0 - {acc, q}) : {acc, q};
        quo_fix  = neg_lo ? (32'd0 - q) : q;
        rem_fix  = neg_hi ? (32'd0 - acc) : acc;
    end

    // Sequencer FSM with registered busy/done and the HI/LO pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MDS_IDLE;
            cnt    <= 5'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            m_reg  <= 32'd0;
            acc    <= 32'd0;
            q      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                MDS_IDLE: begin
                    if (start && !cancel) begin
                        case (md_op)
                            MD_MTHI: hi <= opa;
                            MD_MTLO: lo <= opa;
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                is_div <= op_div;
                                cnt    <= 5'd0;
                                acc    <= 32'd0;
                                busy   <= 1'b1;
                                state  <= MDS_CALC;
                                if (op_div && (opb == 32'd0)) begin
                                    // Zero divisor: raw dividend shifts into acc and q fills with ones.
                                    q      <= opa;
                                    m_reg  <= 32'd0;
                                    neg_lo <= 1'b0;
                                    neg_hi <= 1'b0;
                                end else if (op_div) begin
                                    q      <= a_mag;
                                    m_reg  <= b_mag;
                                    neg_lo <= op_signed & (opa[31] ^ opb[31]);
                                    neg_hi <= op_signed & opa[31];
                                end else begin
                                    q      <= b_mag;
                                    m_reg  <= a_mag;
                                    neg_lo <= op_signed & (opa[31] ^ opb[31]);
                                    neg_hi <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MDS_CALC: begin
                    if (cancel) begin
                        state <= MDS_IDLE;
                        busy  <= 1'b0;
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        if (!is_div) begin
                            {acc, q} <= fast_prod;
                            state    <= MDS_FIXUP;
                        end else begin
                            acc <= acc_nxt;
                            q   <= q_nxt;
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd31) state <= MDS_FIXUP;
                        end
`else
                        acc <= acc_nxt;
                        q   <= q_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= MDS_FIXUP;
`endif
                    end
                end
                MDS_FIXUP: begin
                    state <= MDS_IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state <= MDS_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking scoreboard bench for mdu_ctrl
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_DONE = 3;
`else
    localparam int MUL_DONE = 34;
`endif
    localparam int DIV_DONE = 34;
    localparam int IGN_CYC  = (MUL_DONE > 5) ? 5 : 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        rd_req;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] cur_hilo;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .md_op  (md_op),
        .opa    (opa),
        .opb    (opb),
        .rd_req (rd_req),
        .cancel (cancel),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        qq;
        logic [31:0]        rr;
        sa = a;
        sb = b;
        case (op)
            MD_MULT:  model = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: model = {32'd0, a} * {32'd0, b};
            MD_DIVU:  model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    model = {rr, qq};
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        opa   = a;
        opb   = b;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_cyc);
        int cyc;
        logic got;
        logic [63:0] e;
        sb_q.push_back(exp);
        issue(op, a, b);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk({tag, "_busy_c1"}, busy, 1);
            if (done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, got, 1);
        e = sb_q.pop_front();
        if (got) begin
            chk({tag, "_done_cycle"}, cyc, exp_cyc);
            chk({tag, "_busy_at_done"}, busy, 0);
            chk({tag, "_hilo"}, {hi, lo}, e);
            cur_hilo = e;
        end
    endtask

    initial begin
        int cyc;
        int dcount;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] e;

        rst = 1'b1; start = 1'b0; md_op = 3'd0; opa = 32'd0; opb = 32'd0;
        rd_req = 1'b0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b0;
        cur_hilo = 64'd0;

        // MTHI in IDLE
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo", lo, 0);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, MUL_DONE);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, MUL_DONE);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, DIV_DONE);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_DONE);
        run_op("divu_zero", MD_DIVU, 32'h0000_0064, 32'd0, 64'h0000_0064_FFFF_FFFF, DIV_DONE);
        run_op("div_zero_neg", MD_DIV, 32'h8000_0005, 32'd0, 64'h8000_0005_FFFF_FFFF, DIV_DONE);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
                   (rop < 3'd2) ? MUL_DONE : DIV_DONE);
        end

        // Stall with rd_req held; second start mid-op must be ignored
        e = 64'hFFFF_FFFF_FFFF_FFEB;
        sb_q.push_back(e);
        rd_req = 1'b1;
        issue(MD_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        for (cyc = 1; cyc <= MUL_DONE; cyc++) begin
            @(negedge clk);
            start = (cyc == IGN_CYC);
            if (cyc == IGN_CYC) begin
                md_op = MD_MULTU; opa = 32'h5; opb = 32'h5;
            end
            chk($sformatf("stall_c%0d", cyc), stall, (cyc < MUL_DONE) ? 1 : 0);
        end
        chk("stall_done", done, 1);
        e = sb_q.pop_front();
        chk("stall_hilo", {hi, lo}, e);
        cur_hilo = e;
        start = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        chk("stall_no_2nd_busy", busy, 0);
        chk("stall_no_2nd_done", done, 0);

        // Cancel in cycle 10
        issue(MD_DIV, 32'd100, 32'd7);
        dcount = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start  = 1'b0;
            cancel = (cyc == 10);
            if (done) dcount++;
            if (cyc == 11) chk("cancel_busy_c11", busy, 0);
        end
        cancel = 1'b0;
        chk("cancel_no_done", dcount, 0);
        chk("cancel_hilo_kept", {hi, lo}, cur_hilo);

        // MTLO issued while busy stays stalled until the divide finishes
        sb_q.push_back(64'h0000_0002_0000_000E);
        issue(MD_DIVU, 32'h0000_0064, 32'h0000_0007);
        for (cyc = 1; cyc <= DIV_DONE; cyc++) begin
            @(negedge clk);
            start = 1'b1; md_op = MD_MTLO; opa = 32'h0000_CAFE; opb = 32'd0;
            if (cyc < DIV_DONE) chk($sformatf("mtlo_stall_c%0d", cyc), stall, 1);
        end
        chk("mtlo_div_done", done, 1);
        chk("mtlo_stall_c34", stall, 0);
        e = sb_q.pop_front();
        chk("mtlo_div_hilo", {hi, lo}, e);
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_applied_lo", lo, 32'h0000_CAFE);
        chk("mtlo_hi_kept", hi, e[63:32]);
        chk("mtlo_busy", busy, 0);

        // Reset in cycle 10 of an op
        issue(MD_DIVU, 32'h1234_5678, 32'h0000_0003);
        for (cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (cyc == 10);
        end
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        chk("rstmid_busy", busy, 0);
        dcount = 0;
        for (cyc = 12; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("rstmid_idle", dcount, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
